// File: rtl/wb_master_arb2.sv
// Two-master pipelined Wishbone B4 arbiter: the bus is held for a whole cycle, accepted requests are
// capped at MAX_PENDING, and a watchdog aborts a cycle whose slave has stopped answering.

module wb_master_arb2_port #(
    parameter int DW = 32
) (
    input  logic          own,
    input  logic          bus_stall,
    input  logic          bus_ack,
    input  logic          bus_err,
    input  logic [DW-1:0] bus_dat,
    output logic          m_stall,
    output logic          m_ack,
    output logic          m_err,
    output logic [DW-1:0] m_dat
);
    assign m_stall = own ? bus_stall : 1'b1;
    assign m_ack   = own & bus_ack;
    assign m_err   = own & bus_err;
    assign m_dat   = own ? bus_dat : '0;
endmodule

module wb_master_arb2 #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int RR_EN          = 1,
    parameter int MAX_PENDING    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic            m0_stall_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic [DW-1:0]   m0_dat_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic            m1_stall_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [DW-1:0]   m1_dat_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    input  logic            s_stall_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic [DW-1:0]   s_dat_i
);
    localparam int SW = DW / 8;
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);
    localparam logic [WW-1:0] WDOG_MAX = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    typedef struct packed {
        logic          cyc;
        logic          stb;
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
    } req_t;

    state_t        state, state_nxt;
    logic          owner, owner_nxt;
    logic          last_grant, last_nxt;
    logic [PW-1:0] pending, pending_nxt;
    logic [WW-1:0] wdog, wdog_nxt;

    req_t [1:0] req;
    req_t       own_req;
    logic       busy, full, accept, resp, timeout, grant;

    assign req[0]  = {m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i};
    assign req[1]  = {m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i};
    assign own_req = req[owner];

    assign busy    = (state == BUSY);
    assign full    = (pending == PEND_MAX);
    assign s_cyc_o = busy & own_req.cyc;
    assign s_stb_o = s_cyc_o & own_req.stb & ~full;
    assign s_we_o  = busy & own_req.we;
    assign s_adr_o = busy ? own_req.adr : '0;
    assign s_dat_o = busy ? own_req.dat : '0;
    assign s_sel_o = busy ? own_req.sel : '0;

    assign accept  = s_stb_o & ~s_stall_i;
    assign resp    = s_ack_i | s_err_i;
    // A response or accept in the expiry cycle counts as progress, so it beats the abort.
    assign timeout = s_cyc_o & (pending != '0) & (wdog == WDOG_MAX) & ~resp & ~accept;

    always_comb begin
        if (req[0].cyc & req[1].cyc)
            grant = (RR_EN != 0) ? ~last_grant : 1'b0;
        else
            grant = req[1].cyc;
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        last_nxt    = last_grant;
        pending_nxt = pending;
        wdog_nxt    = wdog;
        case (state)
            IDLE: begin
                pending_nxt = '0;
                wdog_nxt    = '0;
                if (req[0].cyc | req[1].cyc) begin
                    state_nxt = BUSY;
                    owner_nxt = grant;
                    last_nxt  = grant;
                end
            end
            BUSY: begin
                if (!own_req.cyc || timeout) begin
                    state_nxt   = own_req.cyc ? ABORT : IDLE;
                    pending_nxt = '0;
                    wdog_nxt    = '0;
                end else begin
                    // Responses with nothing outstanding are forwarded but not counted.
                    if (accept && !(resp && pending != '0))
                        pending_nxt = pending + PW'(1);
                    else if (!accept && resp && pending != '0)
                        pending_nxt = pending - PW'(1);
                    if (resp || accept)
                        wdog_nxt = '0;
                    else if (pending != '0)
                        wdog_nxt = wdog + WW'(1);
                end
            end
            ABORT: begin
                pending_nxt = '0;
                wdog_nxt    = '0;
                if (!own_req.cyc)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            pending    <= '0;
            wdog       <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_nxt;
            pending    <= pending_nxt;
            wdog       <= wdog_nxt;
        end
    end

    logic [1:0]         own, m_stall, m_ack, m_err;
    logic [1:0][DW-1:0] m_dat;

    for (genvar i = 0; i < 2; i++) begin : g_port
        assign own[i] = busy & (owner == 1'(i));
        wb_master_arb2_port #(.DW(DW)) u_port (
            .own       (own[i]),
            .bus_stall (s_stall_i | full),
            .bus_ack   (s_ack_i),
            .bus_err   (s_err_i | timeout),
            .bus_dat   (s_dat_i),
            .m_stall   (m_stall[i]),
            .m_ack     (m_ack[i]),
            .m_err     (m_err[i]),
            .m_dat     (m_dat[i])
        );
    end

    assign m0_stall_o = m_stall[0];
    assign m0_ack_o   = m_ack[0];
    assign m0_err_o   = m_err[0];
    assign m0_dat_o   = m_dat[0];
    assign m1_stall_o = m_stall[1];
    assign m1_ack_o   = m_ack[1];
    assign m1_err_o   = m_err[1];
    assign m1_dat_o   = m_dat[1];
endmodule
